// File: rtl/sudoku_rule_checker.sv
// Walks a 9x9 grid through the store's registered read port in row, column and
// box order, and reports the first duplicate digit or out-of-range cell found.
module sudoku_rule_checker (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   output logic       rd_en,
   output logic [3:0] rd_row,
   output logic [3:0] rd_col,
   input  logic [3:0] rd_data,
   output logic       busy,
   output logic       done,
   output logic       err,
   output logic [1:0] err_kind,
   output logic [3:0] err_unit,
   output logic [3:0] err_index
);

   // state    | meaning
   // ST_IDLE  | waiting for start since reset
   // ST_SCAN  | issuing reads and checking returned data
   // ST_FLUSH | all addresses issued, checking the final datum
   // ST_DONE  | result held until the next start
   typedef enum logic [1:0] {ST_IDLE, ST_SCAN, ST_FLUSH, ST_DONE} state_t;

   state_t     state_q, state_d;
   logic [1:0] pass_q, pass_d;
   logic [3:0] unit_q, unit_d;
   logic [3:0] idx_q, idx_d;
   logic       rd_en_q, rd_en_d;
   logic [3:0] rd_row_q, rd_row_d;
   logic [3:0] rd_col_q, rd_col_d;
   logic       tag_vld_q, tag_vld_d;
   logic [1:0] tag_pass_q, tag_pass_d;
   logic [3:0] tag_unit_q, tag_unit_d;
   logic [3:0] tag_idx_q, tag_idx_d;
   logic [8:0] mask_q, mask_d;
   logic       done_q, done_d;
   logic       err_q, err_d;
   logic [1:0] err_kind_q, err_kind_d;
   logic [3:0] err_unit_q, err_unit_d;
   logic [3:0] err_index_q, err_index_d;

   logic [8:0] mask_base;
   logic [8:0] digit_oh;
   logic       range_hit;
   logic       dup_hit;
   logic       last_addr;
   logic [1:0] pass_n;
   logic [3:0] unit_n;
   logic [3:0] idx_n;
   logic [7:0] addr_n;

   function automatic logic [3:0] div3(input logic [3:0] x);
      if (x >= 4'd6)      div3 = 4'd2;
      else if (x >= 4'd3) div3 = 4'd1;
      else                div3 = 4'd0;
   endfunction

   function automatic logic [3:0] mod3(input logic [3:0] x);
      mod3 = x - 4'd3 * div3(x);
   endfunction

   // Returns {row, col} for position k of unit u in the given pass.
   function automatic logic [7:0] cell_addr(input logic [1:0] p, input logic [3:0] u,
                                            input logic [3:0] k);
      case (p)
         2'd0:    cell_addr = {u, k};
         2'd1:    cell_addr = {k, u};
         default: cell_addr = {4'd3 * div3(u) + div3(k), 4'd3 * mod3(u) + mod3(k)};
      endcase
   endfunction

   always_comb begin
      // The first datum of a unit sees an empty mask.
      mask_base = (tag_idx_q == 4'd0) ? 9'd0 : mask_q;
      digit_oh  = (rd_data >= 4'd1 && rd_data <= 4'd9) ? (9'd1 << (rd_data - 4'd1)) : 9'd0;
      range_hit = tag_vld_q && (rd_data > 4'd9);
      dup_hit   = tag_vld_q && |(mask_base & digit_oh);
      last_addr = (pass_q == 2'd2) && (unit_q == 4'd8) && (idx_q == 4'd8);

      pass_n = pass_q;
      unit_n = unit_q;
      idx_n  = idx_q + 4'd1;
      if (idx_q == 4'd8) begin
         idx_n = 4'd0;
         if (unit_q == 4'd8) begin
            unit_n = 4'd0;
            pass_n = pass_q + 2'd1;
         end else begin
            unit_n = unit_q + 4'd1;
         end
      end
      addr_n = cell_addr(pass_n, unit_n, idx_n);

      state_d     = state_q;
      pass_d      = pass_q;
      unit_d      = unit_q;
      idx_d       = idx_q;
      rd_en_d     = rd_en_q;
      rd_row_d    = rd_row_q;
      rd_col_d    = rd_col_q;
      tag_vld_d   = 1'b0;
      tag_pass_d  = tag_pass_q;
      tag_unit_d  = tag_unit_q;
      tag_idx_d   = tag_idx_q;
      mask_d      = mask_q;
      done_d      = done_q;
      err_d       = err_q;
      err_kind_d  = err_kind_q;
      err_unit_d  = err_unit_q;
      err_index_d = err_index_q;

      if (tag_vld_q) mask_d = mask_base | digit_oh;

      case (state_q)
         ST_IDLE, ST_DONE: begin
            if (start) begin
               state_d     = ST_SCAN;
               pass_d      = 2'd0;
               unit_d      = 4'd0;
               idx_d       = 4'd0;
               rd_en_d     = 1'b1;
               rd_row_d    = 4'd0;
               rd_col_d    = 4'd0;
               mask_d      = 9'd0;
               done_d      = 1'b0;
               err_d       = 1'b0;
               err_kind_d  = 2'd0;
               err_unit_d  = 4'd0;
               err_index_d = 4'd0;
            end
         end
         ST_SCAN: begin
            tag_vld_d  = 1'b1;
            tag_pass_d = pass_q;
            tag_unit_d = unit_q;
            tag_idx_d  = idx_q;
            if (last_addr) begin
               state_d = ST_FLUSH;
               rd_en_d = 1'b0;
            end else begin
               pass_d   = pass_n;
               unit_d   = unit_n;
               idx_d    = idx_n;
               rd_row_d = addr_n[7:4];
               rd_col_d = addr_n[3:0];
            end
         end
         ST_FLUSH: begin
            state_d = ST_DONE;
            done_d  = 1'b1;
         end
         default: state_d = ST_IDLE;
      endcase

      // First violation ends the scan; anything still in flight is dropped.
      if (range_hit || dup_hit) begin
         state_d     = ST_DONE;
         rd_en_d     = 1'b0;
         tag_vld_d   = 1'b0;
         done_d      = 1'b1;
         err_d       = 1'b1;
         err_kind_d  = range_hit ? 2'd3 : tag_pass_q;
         err_unit_d  = tag_unit_q;
         err_index_d = tag_idx_q;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         pass_q      <= 2'd0;
         unit_q      <= 4'd0;
         idx_q       <= 4'd0;
         rd_en_q     <= 1'b0;
         rd_row_q    <= 4'd0;
         rd_col_q    <= 4'd0;
         tag_vld_q   <= 1'b0;
         tag_pass_q  <= 2'd0;
         tag_unit_q  <= 4'd0;
         tag_idx_q   <= 4'd0;
         mask_q      <= 9'd0;
         done_q      <= 1'b0;
         err_q       <= 1'b0;
         err_kind_q  <= 2'd0;
         err_unit_q  <= 4'd0;
         err_index_q <= 4'd0;
      end else begin
         state_q     <= state_d;
         pass_q      <= pass_d;
         unit_q      <= unit_d;
         idx_q       <= idx_d;
         rd_en_q     <= rd_en_d;
         rd_row_q    <= rd_row_d;
         rd_col_q    <= rd_col_d;
         tag_vld_q   <= tag_vld_d;
         tag_pass_q  <= tag_pass_d;
         tag_unit_q  <= tag_unit_d;
         tag_idx_q   <= tag_idx_d;
         mask_q      <= mask_d;
         done_q      <= done_d;
         err_q       <= err_d;
         err_kind_q  <= err_kind_d;
         err_unit_q  <= err_unit_d;
         err_index_q <= err_index_d;
      end
   end

   assign rd_en     = rd_en_q;
   assign rd_row    = rd_row_q;
   assign rd_col    = rd_col_q;
   assign busy      = (state_q == ST_SCAN) || (state_q == ST_FLUSH);
   assign done      = done_q;
   assign err       = err_q;
   assign err_kind  = err_kind_q;
   assign err_unit  = err_unit_q;
   assign err_index = err_index_q;

endmodule

// File: tb/tb_sudoku_rule_checker.sv
// Bench for sudoku_rule_checker: directed and randomized grids held in a model
// store, results compared against a straightforward rule-by-rule reference.
module tb_sudoku_rule_checker;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       start = 1'b0;
   logic       rd_en;
   logic [3:0] rd_row;
   logic [3:0] rd_col;
   logic [3:0] rd_data = 4'd0;
   logic       busy;
   logic       done;
   logic       err;
   logic [1:0] err_kind;
   logic [3:0] err_unit;
   logic [3:0] err_index;

   logic [3:0] grid [0:8][0:8];
   logic [3:0] mon_row [0:255];
   logic [3:0] mon_col [0:255];
   int         rd_cnt = 0;
   int         checks = 0;
   int         passed = 0;

   sudoku_rule_checker dut (
      .clk(clk), .rst(rst), .start(start),
      .rd_en(rd_en), .rd_row(rd_row), .rd_col(rd_col), .rd_data(rd_data),
      .busy(busy), .done(done), .err(err),
      .err_kind(err_kind), .err_unit(err_unit), .err_index(err_index)
   );

   always #5 clk = ~clk;

   // Grid store with a registered read port.
   always @(posedge clk) begin
      if (rd_en && rd_row < 4'd9 && rd_col < 4'd9) rd_data <= grid[rd_row][rd_col];
      else if (rd_en) rd_data <= 4'd0;
   end

   always @(negedge clk) begin
      if (rd_en) begin
         if (rd_cnt < 256) begin
            mon_row[rd_cnt] = rd_row;
            mon_col[rd_cnt] = rd_col;
         end
         rd_cnt++;
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) passed++;
      else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
   endtask

   function automatic int exp_row(input int i);
      int p = i / 81, u = (i / 9) % 9, k = i % 9;
      if (p == 0) return u;
      if (p == 1) return k;
      return (u / 3) * 3 + k / 3;
   endfunction

   function automatic int exp_col(input int i);
      int p = i / 81, u = (i / 9) % 9, k = i % 9;
      if (p == 0) return k;
      if (p == 1) return u;
      return (u % 3) * 3 + k % 3;
   endfunction

   // Reference: apply the Sudoku rules unit by unit in scan order.
   task automatic model(output bit e, output int kind, output int unit, output int idx,
                        output int nread);
      bit seen [1:9];
      e = 0; kind = 0; unit = 0; idx = 0; nread = 243;
      for (int n = 0; n < 243; n++) begin
         int v;
         if (n % 9 == 0) for (int d = 1; d <= 9; d++) seen[d] = 0;
         v = int'(grid[exp_row(n)][exp_col(n)]);
         if (v > 9) begin
            e = 1; kind = 3;
         end else if (v != 0 && seen[v]) begin
            e = 1; kind = n / 81;
         end else if (v != 0) begin
            seen[v] = 1;
         end
         if (e) begin
            unit = (n / 9) % 9; idx = n % 9; nread = n + 1;
            return;
         end
      end
   endtask

   task automatic fill_zero();
      for (int r = 0; r < 9; r++) for (int c = 0; c < 9; c++) grid[r][c] = 4'd0;
   endtask

   task automatic fill_solved();
      for (int r = 0; r < 9; r++)
         for (int c = 0; c < 9; c++) grid[r][c] = 4'(((3 * r + r / 3 + c) % 9) + 1);
   endtask

   task automatic run_scan(input string tag, input int hold, input bit e_exp,
                           input int kind_exp, input int unit_exp, input int idx_exp,
                           input int nread);
      int done_edge = -1;
      int exp_edge  = e_exp ? nread + 1 : 244;
      int exp_reads = (e_exp && nread < 243) ? nread + 1 : 243;
      int mism = 0;
      @(negedge clk);
      rd_cnt = 0;
      start  = 1'b1;
      @(posedge clk);
      #1;
      chk({tag, ":busy_e0"}, busy, 1);
      chk({tag, ":done_clr"}, {done, err}, 0);
      if (hold == 1) start = 1'b0;
      for (int e = 1; e <= 300; e++) begin
         @(posedge clk);
         #1;
         if (e == hold - 1) start = 1'b0;
         if (done) begin
            done_edge = e;
            break;
         end
      end
      start = 1'b0;
      chk({tag, ":done_edge"}, done_edge, exp_edge);
      chk({tag, ":err"}, err, e_exp);
      chk({tag, ":busy_end"}, busy, 0);
      if (e_exp) chk({tag, ":err_tag"}, {err_kind, err_unit, err_index},
                     {kind_exp[1:0], unit_exp[3:0], idx_exp[3:0]});
      chk({tag, ":reads"}, rd_cnt, exp_reads);
      for (int i = 0; i < rd_cnt && i < 243; i++)
         if (mon_row[i] != 4'(exp_row(i)) || mon_col[i] != 4'(exp_col(i))) mism++;
      chk({tag, ":addr_seq"}, mism, 0);
      repeat (3) @(posedge clk);
      #1;
      chk({tag, ":hold"}, {done, err, busy, rd_en}, {1'b1, e_exp, 2'b00});
   endtask

   initial begin
      bit   e;
      int   kind, unit, idx, nread;
      fill_zero();
      #2;
      chk("reset_outputs", {rd_en, rd_row, rd_col, busy, done, err, err_kind, err_unit, err_index}, 0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("idle_no_start", {busy, done, rd_en}, 0);

      run_scan("zero", 1, 0, 0, 0, 0, 243);
      fill_solved();
      run_scan("solved", 1, 0, 0, 0, 0, 243);

      fill_zero(); grid[4][2] = 4'd7; grid[4][6] = 4'd7;
      run_scan("row_dup", 1, 1, 0, 4, 6, 43);
      fill_zero(); grid[1][3] = 4'd5; grid[7][3] = 4'd5;
      run_scan("col_dup", 1, 1, 1, 3, 7, 116);
      fill_zero(); grid[0][0] = 4'd9; grid[2][2] = 4'd9;
      run_scan("box_dup", 1, 1, 2, 0, 8, 171);
      fill_solved(); grid[8][8] = 4'd12;
      run_scan("range", 1, 1, 3, 8, 8, 81);

      for (int t = 0; t < 14; t++) begin
         fill_solved();
         for (int r = 0; r < 9; r++)
            for (int c = 0; c < 9; c++) begin
               int x = int'($urandom_range(0, 299));
               if (x < 100) grid[r][c] = 4'd0;
               else if (x < 104) grid[r][c] = 4'($urandom_range(1, 9));
               else if (x < 106) grid[r][c] = 4'($urandom_range(10, 15));
            end
         model(e, kind, unit, idx, nread);
         run_scan($sformatf("rand%0d", t), 1, e, kind, unit, idx, nread);
      end

      fill_solved();
      @(negedge clk);
      start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      repeat (100) @(posedge clk);
      #2 rst = 1'b1;
      #1;
      chk("rst_mid_scan", {rd_en, rd_row, rd_col, busy, done, err, err_kind, err_unit, err_index}, 0);
      @(posedge clk);
      #1;
      chk("rst_held", {rd_en, rd_row, rd_col, busy, done, err, err_kind, err_unit, err_index}, 0);
      @(negedge clk);
      rst = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("post_rst_idle", {busy, rd_en, done}, 0);
      run_scan("start_held3", 3, 0, 0, 0, 0, 243);

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
